mod_exp_sequencer: RTL and testbench
====================================

Name: mod_exp_sequencer

Overview:
- Initiator side of the start/done modular-multiply handshake used by the RSA datapath.
- Computes y^d mod N with right-to-left square-and-multiply.
- Issues one a*b mod N request at a time to an external modular-product engine through the mul_* port group.
- Sits between the RSA top-level control (start/done, operands) and the multiply engine.

Parameters:
- EXP_BITS, 256: exponent width; number of exponent bits scanned.
- OPW, 257: operand/result width on the multiply port group; must equal EXP_BITS+1.
- MUL_K, 256: constant value driven on mul_k.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request; sampled only in IDLE
- N  input  EXP_BITS  modulus; requirement N>1
- y  input  EXP_BITS  base; requirement y<N
- d  input  EXP_BITS  exponent
- result  output  EXP_BITS  y^d mod N; valid while done=1, held until next accepted start
- done  output  1  one-cycle completion pulse
- busy  output  1  high from the cycle after start is accepted until the cycle done pulses
- mul_start  output  1  one-cycle request pulse to engine
- mul_a  output  OPW  multiplicand, zero-extended
- mul_b  output  OPW  multiplier, zero-extended
- mul_N  output  OPW  modulus, zero-extended
- mul_k  output  11  constant MUL_K
- mul_done  input  1  engine completion pulse
- mul_result  input  OPW  engine product; sampled only in the mul_done cycle

Behaviour:
- Reset values: result=0, done=0, busy=0, mul_start=0, mul_a=0, mul_b=0, mul_N=0. Internal registers: acc=1, base=0, idx=0, state=IDLE.
- Reset asserted mid-operation returns to IDLE immediately. An in-flight engine response arriving later is ignored.
- States: IDLE, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE.
- IDLE: on start, latch N, y, d; set acc=1, base=y, idx=0; go to MUL_REQ if d[0] else SQR_REQ. start in any other state is ignored.
- MUL_REQ: drive mul_a=acc, mul_b=base, pulse mul_start for exactly 1 cycle; go to MUL_WAIT.
- MUL_WAIT: on mul_done, acc <= mul_result[EXP_BITS-1:0], then take the next-step decision.
- SQR_REQ: drive mul_a=base, mul_b=base, pulse mul_start; go to SQR_WAIT.
- SQR_WAIT: on mul_done, base <= mul_result[EXP_BITS-1:0]; idx <= idx+1; go to MUL_REQ if d[idx+1] else SQR_REQ.
- Next-step decision after a multiply, or when d[idx]=0:
  - If idx==EXP_BITS-1, go to DONE; the final square is skipped.
  - Otherwise go to SQR_REQ.
- DONE: result <= acc; done pulses 1 cycle; return to IDLE. busy drops in the same cycle done pulses.
- mul_a, mul_b, mul_N are held stable from the mul_start cycle through the mul_done cycle. mul_N = latched N throughout busy.
- mul_done outside MUL_WAIT/SQR_WAIT is ignored. No timeout; engine latency is arbitrary, at least 1 cycle.
- Request count without the optional feature: popcount(d) multiplies + (EXP_BITS-1) squares.
- Latency: start -> done = 2 + sum over requests of (1 + engine latency).
- Operands are always < N, so upper result bits are assumed zero and dropped.

Optional Feature:
- Macro: MOD_EXP_EARLY_TERM_EN
- Defined: at each next-step decision, if d>>(idx+1)==0 (no higher exponent bits set), go directly to DONE and skip the remaining squares. d=0 produces result 1 after zero requests; start -> done = 2 cycles.
- Undefined: all EXP_BITS bit positions are always scanned, as specified above.

Test Plan:
- N=13, y=2, d=10; behavioural engine, 3-cycle latency -> result=10, 2 multiplies; 255 squares without macro, 3 squares with macro.
- N=11, y=3, d=5 -> result=1; mul_a/mul_b/mul_N checked stable from every mul_start through mul_done; mul_k=256 throughout.
- d=0, N=7, y=5 -> result=1, zero multiplies; with macro, done exactly 2 cycles after start.
- start re-pulsed while busy, plus a spurious mul_done in MUL_REQ -> both ignored; result for N=13, y=2, d=10 still 10.
- rst_n asserted during SQR_WAIT, then a new start with N=13, y=6, d=2 -> outputs at reset values immediately; result=10 (36 mod 13).
- Random 256-bit N (odd, >1), y<N, d; random engine latency 1-20 cycles -> result matches reference pow(y,d,N).

Source files
------------

// File: rtl/mod_exp_sequencer.sv
// mod_exp_sequencer: y^d mod N by right-to-left square-and-multiply over an external mod-mul engine.
// Optional macro MOD_EXP_EARLY_TERM_EN: finish as soon as no higher exponent bits remain set.
module mod_exp_sequencer #(
    parameter int EXP_BITS = 256,
    parameter int OPW      = 257,
    parameter int MUL_K    = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [EXP_BITS-1:0] N,
    input  logic [EXP_BITS-1:0] y,
    input  logic [EXP_BITS-1:0] d,
    output logic [EXP_BITS-1:0] result,
    output logic                done,
    output logic                busy,
    output logic                mul_start,
    output logic [OPW-1:0]      mul_a,
    output logic [OPW-1:0]      mul_b,
    output logic [OPW-1:0]      mul_N,
    output logic [10:0]         mul_k,
    input  logic                mul_done,
    input  logic [OPW-1:0]      mul_result
);

    // state    | meaning
    // IDLE     | waiting for start
    // MUL_REQ  | issue acc*base request
    // MUL_WAIT | waiting for multiply product -> acc
    // SQR_REQ  | issue base*base request
    // SQR_WAIT | waiting for square product -> base, advance idx
    // DONE     | publish acc as result, pulse done

    localparam int IW  = $clog2(EXP_BITS);
    localparam int IXW = IW + 1;
`ifdef MOD_EXP_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_REQ  = 3'd1,
        MUL_WAIT = 3'd2,
        SQR_REQ  = 3'd3,
        SQR_WAIT = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [EXP_BITS-1:0] d_q;
    logic [EXP_BITS-1:0] acc_q, acc_d;
    logic [EXP_BITS-1:0] base_q, base_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IXW-1:0]      idx_inc;
    logic [EXP_BITS-1:0] d_sh1, d_sh2;
    logic [EXP_BITS-1:0] prod;
    logic                unused_hi;

    // Operands stay below N, so the engine's top product bit is always zero.
    assign prod      = mul_result[EXP_BITS-1:0];
    assign unused_hi = ^mul_result[OPW-1:EXP_BITS];
    assign mul_k     = 11'(MUL_K);
    assign idx_inc   = IXW'(idx_q) + IXW'(1);
    assign d_sh1     = d_q >> idx_inc;
    assign d_sh2     = d_q >> (idx_inc + IXW'(1));

    function automatic state_t step_after(input logic last, input logic rest_zero);
        if (last || (EARLY_TERM && rest_zero)) begin
            return DONE;
        end
        return SQR_REQ;
    endfunction

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        base_d  = base_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = EXP_BITS'(1);
                    base_d  = y;
                    idx_d   = '0;
                    state_d = d[0] ? MUL_REQ : step_after(1'b0, (d >> 1) == '0);
                end
            end
            MUL_REQ: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done) begin
                    acc_d   = prod;
                    state_d = step_after(idx_q == IW'(EXP_BITS - 1), d_sh1 == '0);
                end
            end
            SQR_REQ: state_d = SQR_WAIT;
            SQR_WAIT: begin
                if (mul_done) begin
                    base_d = prod;
                    idx_d  = idx_inc[IW-1:0];
                    if (d_sh1[0]) begin
                        state_d = MUL_REQ;
                    end else begin
                        state_d = step_after(idx_inc == IXW'(EXP_BITS - 1), d_sh2 == '0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            d_q       <= '0;
            acc_q     <= EXP_BITS'(1);
            base_q    <= '0;
            idx_q     <= '0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_N     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            done    <= (state_q == DONE);
            if (state_q == IDLE && start) begin
                d_q   <= d;
                mul_N <= OPW'(N);
                busy  <= 1'b1;
            end
            if (state_q == DONE) begin
                result <= acc_q;
                busy   <= 1'b0;
            end
            // Request operands are registered on entry to a REQ state and then held
            // untouched until the next request, covering the whole engine wait.
            mul_start <= (state_d == MUL_REQ) || (state_d == SQR_REQ);
            if (state_d == MUL_REQ) begin
                mul_a <= OPW'(acc_d);
                mul_b <= OPW'(base_d);
            end else if (state_d == SQR_REQ) begin
                mul_a <= OPW'(base_d);
                mul_b <= OPW'(base_d);
            end
        end
    end

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Self-checking bench for mod_exp_sequencer: behavioural engine, pow reference, per-cycle port monitor.
module tb_mod_exp_sequencer;
    localparam int EB    = 256;
    localparam int OPW   = 257;
    localparam int MK    = 256;
    localparam int LIMIT = 20000;
`ifdef MOD_EXP_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [EB-1:0]  N = '0, y = '0, d = '0;
    logic [EB-1:0]  result;
    logic           done, busy, mul_start;
    logic [OPW-1:0] mul_a, mul_b, mul_N;
    logic [10:0]    mul_k;
    logic           mul_done = 1'b0;
    logic [OPW-1:0] mul_result = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_exp_sequencer #(.EXP_BITS(EB), .OPW(OPW), .MUL_K(MK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .N(N), .y(y), .d(d),
        .result(result), .done(done), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_N(mul_N),
        .mul_k(mul_k), .mul_done(mul_done), .mul_result(mul_result)
    );

    task automatic chk(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EB-1:0] mulmod(input logic [EB-1:0] a, input logic [EB-1:0] b,
                                             input logic [EB-1:0] n);
        logic [2*EB-1:0] p, m;
        p = {{EB{1'b0}}, a} * {{EB{1'b0}}, b};
        m = p % {{EB{1'b0}}, n};
        return m[EB-1:0];
    endfunction

    // Left-to-right exponentiation, independent of the DUT's scan order.
    function automatic logic [EB-1:0] ref_pow(input logic [EB-1:0] a, input logic [EB-1:0] e,
                                              input logic [EB-1:0] n);
        logic [EB-1:0] r;
        r = EB'(1);
        for (int i = EB - 1; i >= 0; i--) begin
            r = mulmod(r, r, n);
            if (e[i]) r = mulmod(r, a, n);
        end
        return r;
    endfunction

    function automatic int exp_requests(input logic [EB-1:0] e);
        int pc, msb;
        pc  = 0;
        msb = -1;
        for (int i = 0; i < EB; i++) begin
            if (e[i]) begin
                pc++;
                msb = i;
            end
        end
        if (EARLY) return pc + ((msb < 0) ? 0 : msb);
        return pc + EB - 1;
    endfunction

    function automatic logic [EB-1:0] rand256();
        logic [EB-1:0] v;
        for (int i = 0; i < EB / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Behavioural engine: latency is cycles from the mul_start cycle to the mul_done cycle.
    int            eng_lat_fixed = 3;
    int            spur_idx = -1;
    int            req_cnt = 0;
    int            lat_sum = 0;
    bit            eng_busy = 1'b0;
    int            eng_cnt = 0;
    logic [EB-1:0] ea, eb, en;
    logic          real_done = 1'b0;

    initial begin
        int lat;
        forever begin
            @(posedge clk);
            #1;
            mul_done  = 1'b0;
            real_done = 1'b0;
            if (eng_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_busy   = 1'b0;
                    mul_done   = 1'b1;
                    real_done  = 1'b1;
                    mul_result = {1'b0, mulmod(ea, eb, en)};
                end
            end else if (mul_start && rst_n) begin
                ea  = mul_a[EB-1:0];
                eb  = mul_b[EB-1:0];
                en  = mul_N[EB-1:0];
                lat = (eng_lat_fixed > 0) ? eng_lat_fixed : int'($urandom_range(1, 20));
                eng_cnt  = lat;
                eng_busy = 1'b1;
                lat_sum += 1 + lat;
                if (req_cnt == spur_idx) begin
                    mul_done   = 1'b1;
                    mul_result = OPW'(5);
                end
                req_cnt++;
            end
        end
    end

    // Per-cycle monitor: busy tracking, request operand stability, mul_N and mul_k.
    bit             exp_busy = 1'b0;
    bit             in_req = 1'b0;
    logic [EB-1:0]  lat_N = '0;
    logic [OPW-1:0] ca, cb, cn;

    always @(posedge clk) begin
        if (rst_n && start && !exp_busy) begin
            exp_busy = 1'b1;
            lat_N    = N;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_busy = 1'b0;
            in_req   = 1'b0;
        end
        chk("mul_k", OPW'(mul_k), OPW'(MK));
        if (done) begin
            chk("done_only_when_busy", OPW'(exp_busy), OPW'(1));
            exp_busy = 1'b0;
        end
        chk("busy", OPW'(busy), OPW'(exp_busy));
        if (exp_busy) chk("mul_N_latched", mul_N, {1'b0, lat_N});
        if (mul_start) begin
            chk("mul_start_overlap", OPW'(in_req), OPW'(0));
            chk("mul_start_while_busy", OPW'(exp_busy), OPW'(1));
            chk("mul_a_zext", OPW'(mul_a[OPW-1]), OPW'(0));
            chk("mul_b_zext", OPW'(mul_b[OPW-1]), OPW'(0));
            in_req = 1'b1;
            ca = mul_a;
            cb = mul_b;
            cn = mul_N;
        end else if (in_req) begin
            chk("mul_a_stable", mul_a, ca);
            chk("mul_b_stable", mul_b, cb);
            chk("mul_N_stable", mul_N, cn);
        end
        if (real_done) in_req = 1'b0;
    end

    task automatic run_op(input logic [EB-1:0] n_i, input logic [EB-1:0] y_i, input logic [EB-1:0] d_i,
                          input int lat, input int rp_at, input int spur,
                          input bit has_lit, input logic [EB-1:0] lit, input string tag);
        int            cyc;
        bit            got;
        logic [EB-1:0] want;
        int            want_reqs;
        want          = ref_pow(y_i, d_i, n_i);
        want_reqs     = exp_requests(d_i);
        eng_lat_fixed = lat;
        spur_idx      = spur;
        req_cnt       = 0;
        lat_sum       = 0;
        @(posedge clk);
        #1;
        N = n_i;
        y = y_i;
        d = d_i;
        start = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc <= LIMIT) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == rp_at) begin
                    start = 1'b1;
                    N = EB'(7);
                    y = EB'(3);
                    d = '1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: no done after %0d cycles", tag, cyc);
        end else begin
            chk({tag, "_result"}, OPW'(result), OPW'(want));
            if (has_lit) chk({tag, "_result_literal"}, OPW'(result), OPW'(lit));
            chk({tag, "_requests"}, OPW'(req_cnt), OPW'(want_reqs));
            chk({tag, "_latency"}, OPW'(cyc), OPW'(2 + lat_sum));
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, OPW'(done), OPW'(0));
        end
        start = 1'b0;
    endtask

    initial begin
        logic [EB-1:0] rn, ry, rd;
        #12;
        chk("rst_result", OPW'(result), OPW'(0));
        chk("rst_done", OPW'(done), OPW'(0));
        chk("rst_busy", OPW'(busy), OPW'(0));
        chk("rst_mul_start", OPW'(mul_start), OPW'(0));
        chk("rst_mul_a", mul_a, OPW'(0));
        chk("rst_mul_b", mul_b, OPW'(0));
        chk("rst_mul_N", mul_N, OPW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(EB'(13), EB'(2), EB'(10), 3, 0, -1, 1'b1, EB'(10), "pow_13_2_10");
        run_op(EB'(11), EB'(3), EB'(5), 2, 0, -1, 1'b1, EB'(1), "pow_11_3_5");
        run_op(EB'(7), EB'(5), EB'(0), 1, 0, -1, 1'b1, EB'(1), "pow_d_zero");
        // Second request of d=10 is a multiply; spurious mul_done lands in its REQ cycle.
        run_op(EB'(13), EB'(2), EB'(10), 3, 3, 1, 1'b1, EB'(10), "ignore_start_spurious");

        // Reset while the first (square) request of d=10 is in flight.
        eng_lat_fixed = 3;
        spur_idx      = -1;
        req_cnt       = 0;
        @(posedge clk);
        #1;
        N = EB'(13);
        y = EB'(2);
        d = EB'(10);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        chk("rst_test_first_request", OPW'(req_cnt), OPW'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", OPW'(result), OPW'(0));
        chk("midrst_done", OPW'(done), OPW'(0));
        chk("midrst_busy", OPW'(busy), OPW'(0));
        chk("midrst_mul_start", OPW'(mul_start), OPW'(0));
        chk("midrst_mul_a", mul_a, OPW'(0));
        chk("midrst_mul_b", mul_b, OPW'(0));
        chk("midrst_mul_N", mul_N, OPW'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("after_rst_idle_busy", OPW'(busy), OPW'(0));
        chk("after_rst_engine_drained", OPW'(eng_busy), OPW'(0));
        run_op(EB'(13), EB'(6), EB'(2), 3, 0, -1, 1'b1, EB'(10), "pow_after_reset");

        for (int r = 0; r < 5; r++) begin
            rn = rand256() | EB'(1);
            if (rn <= EB'(1)) rn = EB'(3);
            ry = rand256() % rn;
            rd = rand256();
            if (r == 1) rd = rd & EB'(32'hFFFF_FFFF);
            run_op(rn, ry, rd, 0, 0, -1, 1'b0, '0, "random");
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
